simon_sequencer: RTL and testbench



---
 rtl/simon_pkg.sv | 22 ++
 rtl/simon_seq_mem.sv | 29 ++
 rtl/simon_sequencer.sv | 139 +++++++++++++
 tb/tb_simon_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared types for the Simon Says game-flow controller: colour encoding
// and the sequencer state set.
package simon_pkg;

    typedef logic [1:0] colour_t;

    localparam colour_t RED    = 2'd0;
    localparam colour_t GREEN  = 2'd1;
    localparam colour_t BLUE   = 2'd2;
    localparam colour_t YELLOW = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        EXTEND,
        SHOW_ON,
        SHOW_GAP,
        INPUT,
        LOSE,
        WIN
    } state_t;

endpackage

// File: rtl/simon_seq_mem.sv
// Pattern store: 2-bit register file, one synchronous write port and one
// asynchronous read port. Contents are not reset.
module simon_seq_mem
    import simon_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int LENW    = $clog2(MAX_LEN + 1)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [LENW-1:0] waddr,
    input  colour_t         wdata,
    input  logic [LENW-1:0] raddr,
    output colour_t         rdata
);

    // Depth covers the whole index range so every counter value is a legal
    // address; entries at or beyond MAX_LEN are simply never written.
    colour_t mem [0:(1 << LENW) - 1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/simon_sequencer.sv
// Simon Says game-flow controller: grows the pattern each round, plays it
// back on the LEDs, then checks the player's presses against it.
module simon_sequencer
    import simon_pkg::*;
#(
    parameter int MAX_LEN     = 16,
    parameter int SHOW_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int LENW        = $clog2(MAX_LEN + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      rand_in,
    input  logic            btn_valid,
    input  logic [1:0]      btn,
    output logic            led_valid,
    output logic [1:0]      led,
    output logic            await_input,
    output logic [LENW-1:0] round,
    output logic            game_over,
    output logic            win
);

    localparam int TMAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    state_t          state, state_n;
    logic [LENW-1:0] len, len_n;
    logic [LENW-1:0] idx, idx_n;
    logic [TW-1:0]   timer, timer_n;
    colour_t         led_q, led_n;
    logic [LENW-1:0] rd_addr;
    colour_t         rd_data;
    logic            we;

    // The read port looks one step ahead so led can be loaded on the same
    // edge that enters SHOW_ON, keeping led a plain register.
    assign we      = (state == EXTEND);
    assign rd_addr = (state == EXTEND)   ? '0 :
                     (state == SHOW_GAP) ? idx + LENW'(1) : idx;

    simon_seq_mem #(
        .MAX_LEN (MAX_LEN),
        .LENW    (LENW)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (len),
        .wdata (rand_in),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            len   <= '0;
            idx   <= '0;
            timer <= '0;
            led_q <= RED;
        end else begin
            state <= state_n;
            len   <= len_n;
            idx   <= idx_n;
            timer <= timer_n;
            led_q <= led_n;
        end
    end

    always_comb begin
        state_n = state;
        len_n   = len;
        idx_n   = idx;
        timer_n = timer;
        led_n   = led_q;
        case (state)
            IDLE, LOSE, WIN: begin
                if (start) begin
                    state_n = EXTEND;
                    len_n   = '0;
                end
            end
            EXTEND: begin
                len_n   = len + LENW'(1);
                idx_n   = '0;
                timer_n = '0;
                state_n = SHOW_ON;
                // In the first round mem[0] is being written this very edge.
                led_n   = (len == '0) ? rand_in : rd_data;
            end
            SHOW_ON: begin
                if (timer == TW'(SHOW_CYCLES - 1)) begin
                    timer_n = '0;
                    state_n = SHOW_GAP;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            SHOW_GAP: begin
                if (timer == TW'(GAP_CYCLES - 1)) begin
                    timer_n = '0;
                    if (idx == len - LENW'(1)) begin
                        idx_n   = '0;
                        state_n = INPUT;
                    end else begin
                        idx_n   = idx + LENW'(1);
                        led_n   = rd_data;
                        state_n = SHOW_ON;
                    end
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            INPUT: begin
                if (btn_valid) begin
                    if (btn != rd_data) begin
                        state_n = LOSE;
                    end else if (idx < len - LENW'(1)) begin
                        idx_n = idx + LENW'(1);
                    end else if (len < LENW'(MAX_LEN)) begin
                        state_n = EXTEND;
                    end else begin
                        state_n = WIN;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign led_valid   = (state == SHOW_ON);
    assign led         = led_q;
    assign await_input = (state == INPUT);
    assign round       = len;
    assign game_over   = (state == LOSE);
    assign win         = (state == WIN);

endmodule

// File: tb/tb_simon_sequencer.sv
// Directed self-checking bench for simon_sequencer with MAX_LEN=3,
// SHOW_CYCLES=4, GAP_CYCLES=2.
module tb_simon_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] rand_in = 2'd0;
    logic       btn_valid = 1'b0;
    logic [1:0] btn = 2'd0;
    logic       led_valid;
    logic [1:0] led;
    logic       await_input;
    logic [1:0] round_val;
    logic       game_over;
    logic       win;

    int total_checks = 0;
    int passed_checks = 0;

    simon_sequencer #(
        .MAX_LEN     (3),
        .SHOW_CYCLES (4),
        .GAP_CYCLES  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .rand_in     (rand_in),
        .btn_valid   (btn_valid),
        .btn         (btn),
        .led_valid   (led_valid),
        .led         (led),
        .await_input (await_input),
        .round       (round_val),
        .game_over   (game_over),
        .win         (win)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total_checks++;
        if (got !== exp)
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        else
            passed_checks++;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".led_valid"}, led_valid, 0);
        checkOutput({tag, ".led"}, led, 0);
        checkOutput({tag, ".await_input"}, await_input, 0);
        checkOutput({tag, ".round"}, round_val, 0);
        checkOutput({tag, ".game_over"}, game_over, 0);
        checkOutput({tag, ".win"}, win, 0);
    endtask

    // Inputs change right after a falling edge and are sampled at the next
    // rising edge; outputs are checked on falling edges.
    task automatic applyStimulus(input logic do_start, input logic do_press, input logic [1:0] colour);
        start     = do_start;
        btn_valid = do_press;
        btn       = colour;
        @(negedge clk);
        start     = 1'b0;
        btn_valid = 1'b0;
    endtask

    // One colour of playback: 4 lit cycles then 2 dark cycles with led held.
    // With noisy set, start and a wrong press are injected every cycle.
    task automatic playColour(input string tag, input logic [1:0] colour, input logic noisy);
        for (int i = 0; i < 6; i++) begin
            if (noisy) begin
                start     = 1'b1;
                btn_valid = 1'b1;
                btn       = ~colour;
            end
            @(negedge clk);
            start     = 1'b0;
            btn_valid = 1'b0;
            checkOutput({tag, ".led_valid"}, led_valid, (i < 4) ? 8'd1 : 8'd0);
            checkOutput({tag, ".led"}, led, colour);
            checkOutput({tag, ".await"}, await_input, 0);
        end
    endtask

    task automatic expectInput(input string tag, input logic [1:0] rnd);
        @(negedge clk);
        checkOutput({tag, ".await_input"}, await_input, 1);
        checkOutput({tag, ".round"}, round_val, rnd);
        checkOutput({tag, ".led_valid"}, led_valid, 0);
    endtask

    initial begin
        // Power-up reset
        repeat (2) @(negedge clk);
        checkAllZero("por");
        rst = 1'b1;
        @(negedge clk);

        // Reset asserted mid-SHOW_ON takes effect immediately
        rand_in = 2'd2;
        applyStimulus(1'b1, 1'b0, 2'd0);
        repeat (2) @(negedge clk);
        checkOutput("pre_rst.led_valid", led_valid, 1);
        checkOutput("pre_rst.led", led, 2);
        #2 rst = 1'b0;
        #1 checkAllZero("async_rst");
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkAllZero("after_rst");

        // Round 1: single colour 2
        rand_in = 2'd2;
        applyStimulus(1'b1, 1'b0, 2'd0);
        checkOutput("r1_extend.round", round_val, 0);
        checkOutput("r1_extend.led_valid", led_valid, 0);
        playColour("r1_c0", 2'd2, 1'b0);
        expectInput("r1_in", 2'd1);

        // Round 2: pattern 2,1 with junk on start/btn_valid during playback
        rand_in = 2'd1;
        applyStimulus(1'b0, 1'b1, 2'd2);
        checkOutput("r2_extend.await", await_input, 0);
        playColour("r2_c0", 2'd2, 1'b1);
        playColour("r2_c1", 2'd1, 1'b1);
        expectInput("r2_in", 2'd2);

        // Wrong second press loses the game
        applyStimulus(1'b0, 1'b1, 2'd2);
        checkOutput("r2_p0.await", await_input, 1);
        checkOutput("r2_p0.game_over", game_over, 0);
        applyStimulus(1'b0, 1'b1, 2'd3);
        checkOutput("lose.game_over", game_over, 1);
        checkOutput("lose.await", await_input, 0);
        checkOutput("lose.round", round_val, 2);
        applyStimulus(1'b0, 1'b1, 2'd1);
        repeat (2) @(negedge clk);
        checkOutput("lose_hold.game_over", game_over, 1);
        checkOutput("lose_hold.led_valid", led_valid, 0);

        // Restart clears game_over; new pattern 3,0,1 played to a win
        rand_in = 2'd3;
        applyStimulus(1'b1, 1'b0, 2'd0);
        checkOutput("restart.game_over", game_over, 0);
        checkOutput("restart.round", round_val, 0);
        playColour("g2r1_c0", 2'd3, 1'b0);
        expectInput("g2r1_in", 2'd1);

        rand_in = 2'd0;
        applyStimulus(1'b0, 1'b1, 2'd3);
        playColour("g2r2_c0", 2'd3, 1'b0);
        playColour("g2r2_c1", 2'd0, 1'b0);
        expectInput("g2r2_in", 2'd2);

        applyStimulus(1'b0, 1'b1, 2'd3);
        rand_in = 2'd1;
        applyStimulus(1'b0, 1'b1, 2'd0);
        checkOutput("g2r3_extend.await", await_input, 0);
        playColour("g2r3_c0", 2'd3, 1'b0);
        playColour("g2r3_c1", 2'd0, 1'b0);
        playColour("g2r3_c2", 2'd1, 1'b0);
        expectInput("g2r3_in", 2'd3);

        applyStimulus(1'b0, 1'b1, 2'd3);
        applyStimulus(1'b0, 1'b1, 2'd0);
        checkOutput("g2r3_p1.win", win, 0);
        checkOutput("g2r3_p1.await", await_input, 1);
        applyStimulus(1'b0, 1'b1, 2'd1);
        checkOutput("win.win", win, 1);
        checkOutput("win.await", await_input, 0);
        checkOutput("win.round", round_val, 3);
        checkOutput("win.game_over", game_over, 0);

        // Win is sticky across extra presses and idle cycles
        applyStimulus(1'b0, 1'b1, 2'd2);
        repeat (3) @(negedge clk);
        checkOutput("win_hold.win", win, 1);
        checkOutput("win_hold.round", round_val, 3);
        checkOutput("win_hold.led_valid", led_valid, 0);

        // Start from WIN clears win
        applyStimulus(1'b1, 1'b0, 2'd0);
        checkOutput("win_restart.win", win, 0);
        checkOutput("win_restart.round", round_val, 0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
